// File: rtl/fp_mult_normalize_round_if.sv
// Operand/product bus into the FP multiplier normalize/round stage and the packed result bus out of it.
// Handshake: a transfer happens on a rising edge where valid && ready; a source holds valid and data until that edge.
interface fp_mult_normalize_round_if #(
   parameter int FRAC_W = 23,
   parameter int EXP_W  = 8
);
   logic                    in_valid;
   logic                    in_ready;
   logic                    sign_in;
   logic [EXP_W-1:0]        exp_a;
   logic [EXP_W-1:0]        exp_b;
   logic [FRAC_W-1:0]       frac_a;
   logic [FRAC_W-1:0]       frac_b;
   logic [FRAC_W-1:0]       hi_product;
   logic [FRAC_W-1:0]       low_product;
   logic                    out_valid;
   logic                    out_ready;
   logic [EXP_W+FRAC_W:0]   result;
   logic                    flag_ovf;
   logic                    flag_unf;
   logic                    flag_inexact;

   modport master (
      output in_valid, sign_in, exp_a, exp_b, frac_a, frac_b, hi_product, low_product, out_ready,
      input  in_ready, out_valid, result, flag_ovf, flag_unf, flag_inexact
   );

   modport slave (
      input  in_valid, sign_in, exp_a, exp_b, frac_a, frac_b, hi_product, low_product, out_ready,
      output in_ready, out_valid, result, flag_ovf, flag_unf, flag_inexact
   );
endinterface

// File: rtl/fp_mult_normalize_round.sv
// FP multiplier back end: rebuild the significand product, normalize, round-to-nearest-even, pack.
// Define FP_NORM_SPECIALS_EN to treat exponent field all-ones as inf/NaN instead of an ordinary value.
module fp_mult_normalize_round #(
   parameter int FRAC_W = 23,
   parameter int EXP_W  = 8,
   parameter int BIAS   = 127
) (
   input  logic                      clk,
   input  logic                      reset,
   fp_mult_normalize_round_if.slave  bus,
   output logic [2:0]                dbg_state
);
   localparam int PW = 2*FRAC_W + 2;
   localparam int EW = EXP_W + 2;
   localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] BIAS_E  = EW'(BIAS);
   localparam logic signed [EW-1:0] E_ZERO  = '0;
   localparam logic signed [EW-1:0] E_ONE   = EW'(1);

   typedef enum logic [2:0] {IDLE, ASSEMBLE, NORM, ROUND, DONE} state_t;
   state_t state, state_next;

   logic                  sign_q;
   logic [EXP_W-1:0]      exp_a_q, exp_b_q;
   logic [FRAC_W-1:0]     frac_a_q, frac_b_q, hi_q, low_q;
   logic [PW-1:0]         p_q, p_asm;
   logic signed [EW-1:0]  e_q, e_asm, e_rnd;
   logic                  sticky_q;
   logic [EXP_W+FRAC_W:0] result_q, res_c;
   logic                  ovf_q, unf_q, inexact_q;
   logic                  ovf_res, unf_res, inx_res;
   logic [FRAC_W-1:0]     f_trunc;
   logic [FRAC_W:0]       f_sum;
   logic                  guard, sticky_all, round_up, zero_in;
`ifdef FP_NORM_SPECIALS_EN
   logic                  inf_a, inf_b, nan_a, nan_b;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (bus.in_valid) state_next = ASSEMBLE;
         ASSEMBLE: state_next = NORM;
         NORM:     state_next = ROUND;
         ROUND:    state_next = DONE;
         DONE:     if (bus.out_ready) state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state == IDLE);
      bus.out_valid = (state == DONE);
      dbg_state     = state;
   end

   // (1+fa)(1+fb) scaled by 2^46 = 2^46 + fa<<23 + fb<<23 + fa*fb
   always_comb begin
      p_asm = {2'b01, {(2*FRAC_W){1'b0}}}
            + ({{(FRAC_W+2){1'b0}}, frac_a_q} << FRAC_W)
            + ({{(FRAC_W+2){1'b0}}, frac_b_q} << FRAC_W)
            + {2'b00, hi_q, low_q};
      e_asm = $signed({2'b00, exp_a_q}) + $signed({2'b00, exp_b_q}) - BIAS_E;
   end

   always_comb begin
      f_trunc    = p_q[PW-3 -: FRAC_W];
      guard      = p_q[FRAC_W-1];
      sticky_all = (|p_q[FRAC_W-2:0]) | sticky_q;
      round_up   = guard & (sticky_all | f_trunc[0]);
      f_sum      = {1'b0, f_trunc} + {{FRAC_W{1'b0}}, round_up};
      // A mantissa carry leaves f_sum[FRAC_W-1:0] all zero, so only the exponent needs bumping.
      e_rnd      = e_q + $signed({{(EW-1){1'b0}}, f_sum[FRAC_W]});
      zero_in    = (exp_a_q == '0) || (exp_b_q == '0);
      res_c      = {sign_q, e_rnd[EXP_W-1:0], f_sum[FRAC_W-1:0]};
      ovf_res    = 1'b0;
      unf_res    = 1'b0;
      inx_res    = guard | sticky_all;
      if (zero_in) begin
         res_c   = {sign_q, {(EXP_W+FRAC_W){1'b0}}};
         inx_res = 1'b0;
      end else if (e_rnd >= EXP_MAX) begin
         res_c   = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
         ovf_res = 1'b1;
         inx_res = 1'b1;
      end else if (e_rnd <= E_ZERO) begin
         res_c   = {sign_q, {(EXP_W+FRAC_W){1'b0}}};
         unf_res = 1'b1;
         inx_res = 1'b1;
      end
`ifdef FP_NORM_SPECIALS_EN
      inf_a = (exp_a_q == '1) && (frac_a_q == '0);
      inf_b = (exp_b_q == '1) && (frac_b_q == '0);
      nan_a = (exp_a_q == '1) && (frac_a_q != '0);
      nan_b = (exp_b_q == '1) && (frac_b_q != '0);
      if (nan_a || nan_b || (inf_a && exp_b_q == '0) || (inf_b && exp_a_q == '0)) begin
         res_c   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
         ovf_res = 1'b0;
         unf_res = 1'b0;
         inx_res = 1'b0;
      end else if (inf_a || inf_b) begin
         res_c   = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
         ovf_res = 1'b0;
         unf_res = 1'b0;
         inx_res = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sign_q    <= 1'b0;
         exp_a_q   <= '0;
         exp_b_q   <= '0;
         frac_a_q  <= '0;
         frac_b_q  <= '0;
         hi_q      <= '0;
         low_q     <= '0;
         p_q       <= '0;
         e_q       <= '0;
         sticky_q  <= 1'b0;
         result_q  <= '0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
         inexact_q <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               sign_q   <= bus.sign_in;
               exp_a_q  <= bus.exp_a;
               exp_b_q  <= bus.exp_b;
               frac_a_q <= bus.frac_a;
               frac_b_q <= bus.frac_b;
               hi_q     <= bus.hi_product;
               low_q    <= bus.low_product;
            end
            ASSEMBLE: begin
               p_q      <= p_asm;
               e_q      <= e_asm;
               sticky_q <= 1'b0;
            end
            NORM: if (p_q[PW-1]) begin
               p_q      <= p_q >> 1;
               e_q      <= e_q + E_ONE;
               sticky_q <= p_q[0];
            end
            ROUND: begin
               result_q  <= res_c;
               ovf_q     <= ovf_res;
               unf_q     <= unf_res;
               inexact_q <= inx_res;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.result       = result_q;
      bus.flag_ovf     = ovf_q;
      bus.flag_unf     = unf_q;
      bus.flag_inexact = inexact_q;
   end
endmodule
